// File: rtl/uart_echo_pkg.sv
// Shared definitions for the UART echo buffer:
// transform modes, ASCII letter bounds and the byte transform.
package uart_echo_pkg;

  typedef enum logic [1:0] {
    PASS        = 2'd0,
    INVERT_CASE = 2'd1,
    UPPER       = 2'd2,
    LOWER       = 2'd3
  } mode_e;

  localparam logic [7:0] UC_LO = 8'h41;
  localparam logic [7:0] UC_HI = 8'h5A;
  localparam logic [7:0] LC_LO = 8'h61;
  localparam logic [7:0] LC_HI = 8'h7A;

  // Only letters are touched; bit 5 is the ASCII case bit.
  function automatic logic [7:0] xform(
    input logic [7:0] b,
    input mode_e      m
  );
    logic [7:0] r;
    logic       letter;
    r = b;
    letter = (b >= UC_LO && b <= UC_HI) ||
             (b >= LC_LO && b <= LC_HI);
    if (letter) begin
      case (m)
        INVERT_CASE: r[5] = ~b[5];
        UPPER:       r[5] = 1'b0;
        LOWER:       r[5] = 1'b1;
        default:     r    = b;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with explicit occupancy count.
// Storage is never cleared; reset and flush only clear validity.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Echo buffer between UART receiver and transmitter:
// applies a case transform at push and queues bytes.
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter bit DROP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [1:0]             mode,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic [7:0] wdata;

  // In drop mode the source is never stalled; a full push is discarded.
  assign rx_ready = DROP_ON_FULL ? 1'b1 : !full;
  assign push     = rx_valid && rx_ready && !full;
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign wdata    = xform(rx_data, mode_e'(mode));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (DROP_ON_FULL && rx_valid && full) begin
      overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(wdata),
    .rdata(tx_data),
    .count(count),
    .full (full),
    .empty(empty)
  );

endmodule

// File: doc/uart_echo_buffer.md
UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 Parameter DEPTH, default 8, means FIFO entries; power of two, at least 2.
REQ-002 Parameter DROP_ON_FULL, default 0, means 0 = backpressure the source when full, 1 = always accept and discard when full.
REQ-003 Port clk, input, width 1: single clock; all logic is on its rising edge.
REQ-004 Port reset, input, width 1: asynchronous, active-high reset.
REQ-005 Port rx_data, input, width 8: byte from the on-chip UART receiver (data_out).
REQ-006 Port rx_valid, input, width 1: rx_data is valid.
REQ-007 Port rx_ready, output, width 1: block accepts rx_data this cycle.
REQ-008 Port tx_data, output, width 8: byte to the on-chip UART transmitter (data_in).
REQ-009 Port tx_valid, output, width 1: tx_data is valid.
REQ-010 Port tx_ready, input, width 1: transmitter accepts tx_data this cycle.
REQ-011 Port mode, input, width 2: transform select; 0 PASS, 1 INVERT_CASE, 2 UPPER, 3 LOWER.
REQ-012 Port flush, input, width 1: synchronous clear of buffer contents.
REQ-013 Port count, output, width $clog2(DEPTH)+1: current occupancy.
REQ-014 Port overflow, output, width 1: sticky flag, set when a byte is dropped.

Function
REQ-015 A push occurs when rx_valid && rx_ready; a pop occurs when tx_valid && tx_ready.
REQ-016 Transform is applied at push, using the mode value sampled in the push cycle.
REQ-017 Transform applies only to ASCII letters 0x41-0x5A and 0x61-0x7A; every other byte passes unchanged in all modes.
REQ-018 Transform rules: INVERT_CASE XORs bit 5 of a letter; UPPER clears bit 5 of a letter; LOWER sets bit 5 of a letter.
REQ-019 tx_valid = (count != 0); tx_data = the entry at the read pointer, driven from storage with no added register stage.
REQ-020 A byte pushed in cycle N into an empty buffer shall present tx_valid=1 in cycle N+1.
REQ-021 Ordering is strict FIFO; no byte is duplicated or reordered.
REQ-022 rx_ready = 1 when DROP_ON_FULL=1; otherwise rx_ready = (count != DEPTH).
REQ-023 rx_ready shall have no combinational dependence on tx_ready.
REQ-024 Push and pop in the same cycle: both take effect and count is unchanged.
REQ-025 When full, a push is not possible, so a same-cycle pop only decrements count.
REQ-026 With DROP_ON_FULL=1, rx_valid while count==DEPTH discards the byte and sets overflow; this applies even if a pop occurs in the same cycle.
REQ-027 Read and write pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-028 count is tracked explicitly and never exceeds DEPTH or underflows.
REQ-029 flush takes priority over a same-cycle push and pop.
REQ-030 On the cycle after flush is asserted: pointers = 0, count = 0, overflow = 0, and no push from that flush cycle is stored.
REQ-031 Storage contents are not cleared by flush or reset; only validity is cleared.

Reset
REQ-032 Asserting reset immediately, without waiting for clk, forces pointers = 0, count = 0, overflow = 0, tx_valid = 0.
REQ-033 During reset, rx_ready = 1 (DROP_ON_FULL=1) or 1 (empty buffer, DROP_ON_FULL=0).
REQ-034 Reset mid-transfer discards all buffered bytes.
REQ-035 No push or pop is performed while reset is high.
REQ-036 Reset is released by the surrounding logic; the block performs no internal synchronisation of reset.

Structure
REQ-037 A shared package uart_echo_pkg holds the mode encodings (PASS, INVERT_CASE, UPPER, LOWER) and the ASCII letter bound constants.
REQ-038 A single sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/flush/count) holds storage and pointers.
REQ-039 The transform and drop logic live in uart_echo_buffer.
REQ-040 The top level shall be instantiable between the on-chip UART data_out/data_in ports without glue logic.

Verification
REQ-041 Scenario, PASS with tx_ready=1: push 0x41 -> tx_valid=1 next cycle with tx_data=0x41, then count returns to 0.
REQ-042 Scenario, INVERT_CASE: push 0x41, 0x7A, 0x31 -> tx emits 0x61, 0x5A, 0x31 in order.
REQ-043 Scenario, DEPTH=8, DROP_ON_FULL=0, tx_ready=0: push 9 bytes -> rx_ready=0 after the 8th, count=8, overflow=0; then tx_ready=1 drains all 8 in order.
REQ-044 Scenario, DROP_ON_FULL=1, full, tx_ready=0: push 0x55 -> byte dropped, overflow=1, count=8; the first pop yields the oldest byte.
REQ-045 Scenario, simultaneous push/pop at count=3 for 20 cycles (rx_valid=1, tx_ready=1) -> count stays 3; pointers wrap past 7 with data intact.
REQ-046 Scenario, flush with rx_valid=1 at count=5, then asynchronous reset at count=2 -> count=0, tx_valid=0, overflow=0 on each; reset takes effect before the next clk edge.
